// File: rtl/scan_select_gen_if.sv
// Bundle for scan_select_gen: mode/step/clear controls, prescale and
// optional wrap limit in; decoder select lines and status out.
// The limit signal only exists when SCAN_LIMIT_EN is defined.
interface scan_select_gen_if #(
    parameter int PRESCALE_W = 16
);
    logic                  run;
    logic                  step;
    logic                  clr;
    logic [PRESCALE_W-1:0] prescale;
`ifdef SCAN_LIMIT_EN
    logic [2:0]            limit;
`endif
    logic                  x;
    logic                  y;
    logic                  z;
    logic                  sel_valid;
    logic                  frame_done;

`ifdef SCAN_LIMIT_EN
    modport master (
        output run, step, clr, prescale, limit,
        input  x, y, z, sel_valid, frame_done
    );
    modport slave (
        input  run, step, clr, prescale, limit,
        output x, y, z, sel_valid, frame_done
    );
`else
    modport master (
        output run, step, clr, prescale,
        input  x, y, z, sel_valid, frame_done
    );
    modport slave (
        input  run, step, clr, prescale,
        output x, y, z, sel_valid, frame_done
    );
`endif
endinterface

// File: rtl/scan_select_gen.sv
// scan_select_gen: walks a 3-bit select index {x,y,z} for a downstream
// 3-to-8 decoder, advancing every prescale+1 cycles in free-run or once
// per step pulse while held. frame_done pulses on the wrap to index 0.
// Optional feature macro: SCAN_LIMIT_EN (programmable last index via limit).
//
// state | meaning
// IDLE  | after reset; index and prescale count held at 0, outputs invalid
// RUN   | free-running scan, prescaled advance
// HOLD  | index frozen, step pulse advances once
module scan_select_gen #(
    parameter int PRESCALE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    scan_select_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  fd_q, fd_d;
    logic                  adv;
    logic [2:0]            last;

`ifdef SCAN_LIMIT_EN
    assign last = bus.limit;
`else
    assign last = 3'd7;
`endif

    // State, index, prescale count and frame pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            pcnt_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            fd_q    <= fd_d;
        end
    end

    // Next-state, prescale and index advance; clr overrides any advance.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        fd_d    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d  = 3'd0;
                pcnt_d = '0;
                if (bus.run) state_d = RUN;
            end
            RUN: begin
                if (!bus.run) state_d = HOLD;
                // >= so a prescale lowered under the running count still advances
                if (pcnt_q >= bus.prescale) begin
                    adv    = 1'b1;
                    pcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q + PCNT_ONE;
                end
            end
            HOLD: begin
                if (bus.run) begin
                    state_d = RUN;
                end else if (bus.step) begin
                    adv    = 1'b1;
                    pcnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (idx_q >= last) begin
                idx_d = 3'd0;
                fd_d  = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
        if (bus.clr) begin
            idx_d  = 3'd0;
            pcnt_d = '0;
            fd_d   = 1'b0;
        end
    end

    assign bus.x          = idx_q[2];
    assign bus.y          = idx_q[1];
    assign bus.z          = idx_q[0];
    assign bus.frame_done = fd_q;
    assign bus.sel_valid  = (state_q == RUN) || (state_q == HOLD);
endmodule

// File: tb/tb_scan_select_gen.sv
// Directed bench for scan_select_gen. Each step drives inputs just after a
// rising edge and checks registered outputs 1 time unit after the next edge.
module tb_scan_select_gen;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    scan_select_gen_if #(.PRESCALE_W(PW)) bus ();

    scan_select_gen #(.PRESCALE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int idx();
        return int'({bus.x, bus.y, bus.z});
    endfunction

    initial begin
        int fd_count;
        rst          = 1'b1;
        bus.run      = 1'b1;
        bus.step     = 1'b1;
        bus.clr      = 1'b0;
        bus.prescale = '0;
`ifdef SCAN_LIMIT_EN
        bus.limit    = 3'd7;
`endif
        // reset wins over run/step
        tick();
        tick();
        chk("rst_idx", idx(), 0);
        chk("rst_valid", int'(bus.sel_valid), 0);
        chk("rst_fd", int'(bus.frame_done), 0);

        // free run, prescale 0: 0..7,0 on consecutive cycles
        rst      = 1'b0;
        bus.step = 1'b0;
        tick();
        chk("run0_idx", idx(), 0);
        chk("run0_valid", int'(bus.sel_valid), 1);
        chk("run0_fd", int'(bus.frame_done), 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("p0_idx", idx(), i % 8);
            chk("p0_fd", int'(bus.frame_done), (i == 8) ? 1 : 0);
        end

        // prescale 3: advance every 4 cycles, one frame_done per 32
        bus.prescale = PW'(3);
        fd_count = 0;
        for (int t = 1; t <= 32; t++) begin
            tick();
            chk("p3_idx", idx(), (t / 4) % 8);
            if (bus.frame_done) fd_count++;
        end
        chk("p3_fd_last", int'(bus.frame_done), 1);
        chk("p3_fd_count", fd_count, 1);

        // reach index 4, drop run: last RUN cycle advances to 5, then hold
        bus.prescale = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_hold_idx", idx(), 4);
        bus.run = 1'b0;
        tick();
        chk("hold_idx", idx(), 5);
        chk("hold_valid", int'(bus.sel_valid), 1);
        tick();
        chk("hold_frozen", idx(), 5);

        // three step pulses: 6, 7, 0 with frame_done on the third
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        chk("step1_idx", idx(), 6);
        chk("step1_fd", int'(bus.frame_done), 0);
        tick();
        chk("step_gap", idx(), 6);
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        chk("step2_idx", idx(), 7);
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        chk("step3_idx", idx(), 0);
        chk("step3_fd", int'(bus.frame_done), 1);
        tick();
        chk("step3_fd_drop", int'(bus.frame_done), 0);

        // run+step in HOLD: resume without advancing
        bus.run  = 1'b1;
        bus.step = 1'b1;
        tick();
        chk("runstep_idx", idx(), 0);
        // step in RUN ignored (prescale 10, pcnt 0 -> 1)
        bus.prescale = PW'(10);
        tick();
        bus.step = 1'b0;
        chk("step_in_run", idx(), 0);

        // pcnt now 1; five more cycles -> pcnt 6, then prescale 10 -> 2
        for (int i = 0; i < 5; i++) tick();
        chk("ps_before", idx(), 0);
        bus.prescale = PW'(2);
        tick();
        chk("ps_force_adv", idx(), 1);
        tick();
        tick();
        chk("ps_wait", idx(), 1);
        tick();
        chk("ps_period3", idx(), 2);

        // clr coincident with advance from 7
        bus.prescale = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_clr_idx", idx(), 7);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr_idx", idx(), 0);
        chk("clr_fd", int'(bus.frame_done), 0);

        // rst at index 4: frame abandoned, no frame_done
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_idx", idx(), 4);
        rst = 1'b1;
        tick();
        chk("mid_rst_idx", idx(), 0);
        chk("mid_rst_valid", int'(bus.sel_valid), 0);
        chk("mid_rst_fd", int'(bus.frame_done), 0);

        // step ignored in IDLE
        rst      = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("idle_step_idx", idx(), 0);
        chk("idle_valid", int'(bus.sel_valid), 0);

`ifdef SCAN_LIMIT_EN
        // limit 2: 0,1,2,0; then limit 1 while at 2 wraps on next advance
        bus.limit = 3'd2;
        bus.run   = 1'b1;
        tick();
        chk("lim_start", idx(), 0);
        tick(); chk("lim_1", idx(), 1);
        tick(); chk("lim_2", idx(), 2);
        tick(); chk("lim_wrap", idx(), 0);
        chk("lim_wrap_fd", int'(bus.frame_done), 1);
        tick(); chk("lim_1b", idx(), 1);
        tick(); chk("lim_2b", idx(), 2);
        bus.limit = 3'd1;
        tick();
        chk("lim_lower_idx", idx(), 0);
        chk("lim_lower_fd", int'(bus.frame_done), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scan_select_gen.md
SCAN_SELECT_GEN -- requirements
Module: scan_select_gen

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, meaning the prescale counter and prescale input width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port run  input  1  level; 1 = free-run scanning, 0 = hold.
REQ-005 SHALL have port step  input  1  single-cycle pulse; manual advance, honoured only in HOLD.
REQ-006 SHALL have port clr  input  1  single-cycle pulse; index and prescale count to 0, state unchanged.
REQ-007 SHALL have port prescale  input  PRESCALE_W  cycles per advance minus one.
REQ-008 SHALL have port limit  input  3  last index before wrap; present only with SCAN_LIMIT_EN.
REQ-009 SHALL have port x  output  1  index bit 2 (MSB), registered.
REQ-010 SHALL have port y  output  1  index bit 1, registered.
REQ-011 SHALL have port z  output  1  index bit 0 (LSB), registered; {x,y,z} feeds the downstream 3-to-8 decoder.
REQ-012 SHALL have port sel_valid  output  1  1 when state is RUN or HOLD.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse, registered, asserted in the cycle {x,y,z} wraps to 0.

Function
REQ-014 SHALL implement states IDLE, RUN, HOLD.
REQ-015 SHALL transition IDLE->RUN when run=1; RUN->HOLD when run=0; HOLD->RUN when run=1; IDLE is re-entered only via rst.
REQ-016 SHALL, in RUN, increment pcnt each cycle; when pcnt >= prescale, advance index and load pcnt=0; advance period = prescale+1 cycles (prescale=0 -> every cycle).
REQ-017 SHALL compare pcnt >= prescale so a prescale lowered below current pcnt forces an advance on the next RUN cycle.
REQ-018 SHALL, on advance with index >= last, load index=0 and pulse frame_done; otherwise index+1 with frame_done=0.
REQ-019 SHALL use last = 7 without SCAN_LIMIT_EN, last = limit with it; limit lowered below current index wraps to 0 on the next advance.
REQ-020 SHALL, in HOLD, freeze index and pcnt; a step pulse advances index once (same wrap/frame_done rule) and clears pcnt.
REQ-021 SHALL ignore step in IDLE and RUN; run and step both high in HOLD -> enter RUN, no step advance.
REQ-022 SHALL give clr priority over any advance in the same cycle: index=0, pcnt=0, frame_done=0.
REQ-023 SHALL hold index=0, pcnt=0, sel_valid=0, frame_done=0 while in IDLE.
REQ-024 SHALL present updated {x,y,z} one cycle after the advancing edge condition (registered, no combinational input-to-output path).

Reset
REQ-025 SHALL, with rst=1 at a clock edge, set state=IDLE, x=y=z=0, pcnt=0, sel_valid=0, frame_done=0, regardless of run/step/clr.
REQ-026 SHALL, on rst mid-scan, abandon the frame without pulsing frame_done.

Configuration
REQ-027 SHALL compile the limit port and programmable wrap only when macro SCAN_LIMIT_EN is defined.
REQ-028 SHALL, without SCAN_LIMIT_EN, omit the limit port and always wrap after index 7.

Verification
REQ-029 Reset then run=1, prescale=0 -> {x,y,z} 0,1,...,7,0 on consecutive cycles; frame_done exactly in cycle index returns to 0; sel_valid=1 from first RUN cycle.
REQ-030 prescale=3, run=1 -> index advances every 4 cycles; 32 cycles per frame; one frame_done per 32 cycles.
REQ-031 run=0 at index 5, three step pulses -> index 6,7,0; frame_done on third; step in RUN ignored.
REQ-032 clr coincident with an advance from index 7 -> index 0, frame_done=0; rst at index 4 -> next cycle index 0, sel_valid=0, no frame_done.
REQ-033 SCAN_LIMIT_EN, limit=2, prescale=0 -> sequence 0,1,2,0; change limit to 1 while index=2 -> next advance to 0 with frame_done.
REQ-034 prescale changed 10->2 while pcnt=6 -> advance on next cycle, then every 3 cycles.
